trdb_word_buffer: RTL and testbench

TRDB_WORD_BUFFER -- requirements
Module: trdb_word_buffer

---
 rtl/trdb_pkg.sv | 14 +
 rtl/trdb_wordbuf_mem.sv | 25 ++
 rtl/trdb_word_buffer.sv | 152 +++++++++++++++
 tb/tb_trdb_word_buffer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trdb_pkg.sv
// Shared constants and FSM state type for the trace word buffer.
package trdb_pkg;

   localparam int unsigned TRDB_WORDBUF_DEPTH = 16;
   localparam int unsigned TRDB_DROP_CNT_LEN  = 16;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      FLUSH_WAIT = 2'd1,
      DRAIN      = 2'd2,
      DONE       = 2'd3
   } trdb_wordbuf_state_e;

endpackage

// File: rtl/trdb_wordbuf_mem.sv
// DEPTH x 32 flop array: one synchronous write port, one combinational read port.
// The array is intentionally not reset; validity is tracked by the pointers.
module trdb_wordbuf_mem #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/trdb_word_buffer.sv
// Show-ahead trace word buffer with overflow accounting and flush tracking.
// Optional threshold interrupt is enabled by defining TRDB_WORDBUF_IRQ_EN.
module trdb_word_buffer
   import trdb_pkg::*;
#(
   parameter int unsigned DEPTH        = TRDB_WORDBUF_DEPTH,
   parameter int unsigned DROP_CNT_LEN = TRDB_DROP_CNT_LEN
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [31:0]               data_i,
   input  logic                      valid_i,
   input  logic                      flush_confirm_i,
   input  logic                      clear_i,
   input  logic [$clog2(DEPTH):0]    irq_threshold_i,
   output logic [31:0]               data_o,
   output logic                      valid_o,
   input  logic                      ready_i,
   output logic [$clog2(DEPTH):0]    fill_o,
   output logic                      overflow_o,
   output logic [DROP_CNT_LEN-1:0]   drop_cnt_o,
   output logic                      flush_done_o,
   output logic                      irq_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
   logic                    overflow_q, overflow_d;
   logic [DROP_CNT_LEN-1:0] drop_cnt_q, drop_cnt_d;
   trdb_wordbuf_state_e     state_q, state_d;

   logic          full_c;
   logic          pop_c;
   logic          push_c;
   logic          drop_c;
   logic          we_c;
   logic [31:0]   rdata_c;
   logic [PW-1:0] fill_c;

   // Pointers wrap modulo 2*DEPTH; the extra MSB separates full from empty.
   assign fill_c = wr_ptr_q - rd_ptr_q;
   assign full_c = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign pop_c  = valid_o && ready_i;
   assign push_c = valid_i && (!full_c || pop_c);
   assign drop_c = valid_i && full_c && !pop_c;
   assign we_c   = push_c && !clear_i;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      state_d    = state_q;

      if (clear_i) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         overflow_d = 1'b0;
         drop_cnt_d = '0;
         state_d    = RUN;
      end else begin
         if (push_c) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         if (drop_c) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) begin
               drop_cnt_d = drop_cnt_q + DROP_CNT_LEN'(1);
            end
         end

         // Residual aligner word lands one cycle after its confirm, hence FLUSH_WAIT.
         unique case (state_q)
            RUN:        if (flush_confirm_i) state_d = FLUSH_WAIT;
            FLUSH_WAIT: state_d = DRAIN;
            DRAIN:      if ((fill_c == '0) && !valid_i) state_d = DONE;
            DONE:       if (valid_i) state_d = RUN;
            default:    state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
         state_q    <= RUN;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
         state_q    <= state_d;
      end
   end

   trdb_wordbuf_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk_i   (clk_i),
      .we_i    (we_c),
      .waddr_i (wr_ptr_q[AW-1:0]),
      .wdata_i (data_i),
      .raddr_i (rd_ptr_q[AW-1:0]),
      .rdata_o (rdata_c)
   );

   // Head word is forced to zero when empty so stale array contents never leak out.
   assign valid_o      = (fill_c != '0);
   assign data_o       = valid_o ? rdata_c : 32'h0;
   assign fill_o       = fill_c;
   assign overflow_o   = overflow_q;
   assign drop_cnt_o   = drop_cnt_q;
   assign flush_done_o = (state_q == DONE);

`ifdef TRDB_WORDBUF_IRQ_EN
   logic irq_q, irq_d;

   always_comb begin
      irq_d = (irq_threshold_i != '0) && (fill_c >= irq_threshold_i);
      if (clear_i) begin
         irq_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_d;
      end
   end

   assign irq_o = irq_q;
`else
   logic unused_irq_threshold;

   assign unused_irq_threshold = ^irq_threshold_i;
   assign irq_o                = 1'b0;
`endif

endmodule

// File: tb/tb_trdb_word_buffer.sv
// Directed self-checking bench for trdb_word_buffer (DEPTH=16).
module tb_trdb_word_buffer;
   import trdb_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] data_i;
   logic        valid_i;
   logic        flush_confirm_i;
   logic        clear_i;
   logic [4:0]  irq_threshold_i;
   logic [31:0] data_o;
   logic        valid_o;
   logic        ready_i;
   logic [4:0]  fill_o;
   logic        overflow_o;
   logic [15:0] drop_cnt_o;
   logic        flush_done_o;
   logic        irq_o;

   int n_checks = 0;
   int n_errors = 0;

   trdb_word_buffer dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .data_i          (data_i),
      .valid_i         (valid_i),
      .flush_confirm_i (flush_confirm_i),
      .clear_i         (clear_i),
      .irq_threshold_i (irq_threshold_i),
      .data_o          (data_o),
      .valid_o         (valid_o),
      .ready_i         (ready_i),
      .fill_o          (fill_o),
      .overflow_o      (overflow_o),
      .drop_cnt_o      (drop_cnt_o),
      .flush_done_o    (flush_done_o),
      .irq_o           (irq_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   initial begin
      rst_i           = 1'b1;
      data_i          = '0;
      valid_i         = 1'b0;
      flush_confirm_i = 1'b0;
      clear_i         = 1'b0;
      irq_threshold_i = '0;
      ready_i         = 1'b0;
      tick();
      tick();

      check("rst_fill",  64'(fill_o), 64'd0);
      check("rst_valid", 64'(valid_o), 64'd0);
      check("rst_data",  64'(data_o), 64'd0);
      check("rst_ovf",   64'(overflow_o), 64'd0);
      check("rst_drop",  64'(drop_cnt_o), 64'd0);
      check("rst_fdone", 64'(flush_done_o), 64'd0);
      check("rst_irq",   64'(irq_o), 64'd0);
      check("rst_state", 64'(dut.state_q), 64'(RUN));
      rst_i = 1'b0;
      tick();

      // Four words with consumer stalled, then drained in order.
      for (int i = 1; i <= 4; i++) begin
         valid_i = 1'b1;
         data_i  = 32'hA5A5_0000 + 32'(i);
         tick();
         if (i == 1) begin
            check("first_valid", 64'(valid_o), 64'd1);
            check("first_data",  64'(data_o), 64'hA5A5_0001);
         end
      end
      valid_i = 1'b0;
      check("fill4", 64'(fill_o), 64'd4);
      ready_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("pop%0d_valid", i), 64'(valid_o), 64'd1);
         check($sformatf("pop%0d_data", i), 64'(data_o), 64'(32'hA5A5_0000 + 32'(i)));
         tick();
      end
      check("drained_valid", 64'(valid_o), 64'd0);
      check("drained_fill",  64'(fill_o), 64'd0);
      ready_i = 1'b0;

      // Eighteen pushes into a 16-deep buffer: two drops.
      for (int i = 1; i <= 18; i++) begin
         valid_i = 1'b1;
         data_i  = 32'h1000_0000 + 32'(i);
         tick();
      end
      valid_i = 1'b0;
      check("full_fill", 64'(fill_o), 64'd16);
      check("full_ovf",  64'(overflow_o), 64'd1);
      check("full_drop", 64'(drop_cnt_o), 64'd2);
      check("full_head", 64'(data_o), 64'h1000_0001);

      // Simultaneous push and pop while full.
      valid_i = 1'b1;
      data_i  = 32'hDEAD_BEEF;
      ready_i = 1'b1;
      tick();
      valid_i = 1'b0;
      ready_i = 1'b0;
      check("pp_fill", 64'(fill_o), 64'd16);
      check("pp_drop", 64'(drop_cnt_o), 64'd2);
      ready_i = 1'b1;
      for (int i = 2; i <= 16; i++) begin
         check($sformatf("keep%0d", i), 64'(data_o), 64'(32'h1000_0000 + 32'(i)));
         tick();
      end
      check("last_entry", 64'(data_o), 64'hDEAD_BEEF);
      tick();
      check("pp_empty", 64'(valid_o), 64'd0);
      ready_i = 1'b0;

      // Clear with a concurrent push at five entries and sticky overflow.
      for (int i = 1; i <= 5; i++) begin
         valid_i = 1'b1;
         data_i  = 32'h2000_0000 + 32'(i);
         tick();
      end
      check("pre_clr_fill", 64'(fill_o), 64'd5);
      check("pre_clr_ovf",  64'(overflow_o), 64'd1);
      clear_i = 1'b1;
      data_i  = 32'h2000_0006;
      tick();
      clear_i = 1'b0;
      valid_i = 1'b0;
      check("clr_fill",  64'(fill_o), 64'd0);
      check("clr_ovf",   64'(overflow_o), 64'd0);
      check("clr_drop",  64'(drop_cnt_o), 64'd0);
      check("clr_valid", 64'(valid_o), 64'd0);

      // Flush handshake with one residual word.
      ready_i         = 1'b1;
      flush_confirm_i = 1'b1;
      tick();
      flush_confirm_i = 1'b0;
      check("fl_wait",  64'(dut.state_q), 64'(FLUSH_WAIT));
      check("fl_done0", 64'(flush_done_o), 64'd0);
      valid_i = 1'b1;
      data_i  = 32'h0000_00AB;
      tick();
      valid_i = 1'b0;
      check("fl_drain", 64'(dut.state_q), 64'(DRAIN));
      check("fl_resid", 64'(data_o), 64'h0000_00AB);
      check("fl_rvld",  64'(valid_o), 64'd1);
      tick();
      check("fl_popped", 64'(fill_o), 64'd0);
      check("fl_drain2", 64'(dut.state_q), 64'(DRAIN));
      tick();
      check("fl_done",  64'(flush_done_o), 64'd1);
      flush_confirm_i = 1'b1;
      tick();
      flush_confirm_i = 1'b0;
      check("fl_ignore", 64'(dut.state_q), 64'(DONE));
      ready_i = 1'b0;
      valid_i = 1'b1;
      data_i  = 32'h0000_0055;
      tick();
      valid_i = 1'b0;
      check("fl_run",    64'(dut.state_q), 64'(RUN));
      check("fl_done_n", 64'(flush_done_o), 64'd0);
      check("fl_accept", 64'(data_o), 64'h0000_0055);
      check("fl_fill1",  64'(fill_o), 64'd1);
      ready_i = 1'b1;
      tick();
      ready_i = 1'b0;

      // Reset in the middle of a flush.
      flush_confirm_i = 1'b1;
      tick();
      flush_confirm_i = 1'b0;
      valid_i = 1'b1;
      data_i  = 32'h3333_0001;
      tick();
      valid_i = 1'b0;
      check("mr_pre_fill", 64'(fill_o), 64'd1);
      #2 rst_i = 1'b1;
      #1;
      check("mr_fill",  64'(fill_o), 64'd0);
      check("mr_state", 64'(dut.state_q), 64'(RUN));
      check("mr_valid", 64'(valid_o), 64'd0);
      tick();
      rst_i = 1'b0;
      tick();
      tick();
      check("mr_nodone", 64'(flush_done_o), 64'd0);

`ifdef TRDB_WORDBUF_IRQ_EN
      irq_threshold_i = 5'd3;
      for (int i = 1; i <= 3; i++) begin
         valid_i = 1'b1;
         data_i  = 32'h4000_0000 + 32'(i);
         tick();
      end
      valid_i = 1'b0;
      check("irq_lag", 64'(irq_o), 64'd0);
      tick();
      check("irq_set", 64'(irq_o), 64'd1);
      ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
      check("irq_pop_fill", 64'(fill_o), 64'd2);
      tick();
      check("irq_clr", 64'(irq_o), 64'd0);
      irq_threshold_i = 5'd0;
      for (int i = 1; i <= 3; i++) begin
         valid_i = 1'b1;
         tick();
      end
      valid_i = 1'b0;
      tick();
      check("irq_thr0", 64'(irq_o), 64'd0);
`else
      irq_threshold_i = 5'd3;
      for (int i = 1; i <= 4; i++) begin
         valid_i = 1'b1;
         data_i  = 32'h4000_0000 + 32'(i);
         tick();
      end
      valid_i = 1'b0;
      tick();
      check("irq_off_fill", 64'(fill_o), 64'd4);
      check("irq_off", 64'(irq_o), 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
